// File: rtl/lsu_pkg.sv
// Shared constants and types for the RV32I load/store unit.
package lsu_pkg;

  localparam int unsigned XLEN = 32;

  localparam logic [2:0] LSU_B  = 3'b000;
  localparam logic [2:0] LSU_H  = 3'b001;
  localparam logic [2:0] LSU_W  = 3'b010;
  localparam logic [2:0] LSU_BU = 3'b100;
  localparam logic [2:0] LSU_HU = 3'b101;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    RESP,
    FAULT
  } lsu_state_t;

  // Lane-positioned store payload as presented on the data bus.
  typedef struct packed {
    logic [XLEN-1:0] wdata;
    logic [3:0]      strb;
  } lsu_store_t;

endpackage

// File: rtl/load_store_unit_if.sv
// Data-bus request/acknowledge channel between the LSU (master) and memory (slave).
interface load_store_unit_if;
  import lsu_pkg::*;

  logic            bus_req;
  logic            bus_we;
  logic [XLEN-1:0] bus_addr;
  logic [XLEN-1:0] bus_wdata;
  logic [3:0]      bus_strb;
  logic [XLEN-1:0] bus_rdata;
  logic            bus_ack;

  modport master (
    output bus_req, bus_we, bus_addr, bus_wdata, bus_strb,
    input  bus_rdata, bus_ack
  );

  modport slave (
    input  bus_req, bus_we, bus_addr, bus_wdata, bus_strb,
    output bus_rdata, bus_ack
  );

endinterface

// File: rtl/load_formatter.sv
// Extracts and extends the addressed byte/halfword of a load word.
module load_formatter
  import lsu_pkg::*;
(
  input  logic [XLEN-1:0] rdata,
  input  logic [1:0]      offset,
  input  logic [2:0]      funct3,
  output logic [XLEN-1:0] result_c
);

  logic [7:0]  byte_lane;
  logic [15:0] half_lane;

  always_comb begin
    byte_lane = rdata[7:0];
    half_lane = rdata[15:0];
    result_c  = rdata;
    case (offset)
      2'd0:    byte_lane = rdata[7:0];
      2'd1:    byte_lane = rdata[15:8];
      2'd2:    byte_lane = rdata[23:16];
      default: byte_lane = rdata[31:24];
    endcase
    if (offset[1]) half_lane = rdata[31:16];
    case (funct3)
      LSU_B:   result_c = {{24{byte_lane[7]}}, byte_lane};
      LSU_BU:  result_c = {24'd0, byte_lane};
      LSU_H:   result_c = {{16{half_lane[15]}}, half_lane};
      LSU_HU:  result_c = {16'd0, half_lane};
      default: result_c = rdata;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Multi-cycle RV32I data-memory stage: checks, formats and sequences one
// bus access at a time, stalling the core until it completes.
module load_store_unit
  import lsu_pkg::*;
(
  input  logic               clock,
  input  logic               reset,
  input  logic               valid,
  input  logic               is_load,
  input  logic               is_store,
  input  logic [2:0]         funct3,
  input  logic [XLEN-1:0]    addr,
  input  logic [XLEN-1:0]    store_data,
  input  logic [4:0]         rd,
  output logic               stall,
  output logic               fault,
  load_store_unit_if.master  bus,
  output logic               wb_enable,
  output logic [4:0]         wb_reg,
  output logic [XLEN-1:0]    wb_data
);

  lsu_state_t      state;
  logic            mem_op;
  logic            type_ok;
  logic            aligned;
  lsu_store_t      lanes;
  logic            op_load;
  logic [2:0]      op_funct3;
  logic [1:0]      op_offset;
  logic [4:0]      op_rd;
  logic [XLEN-1:0] load_result;

  assign mem_op = valid & (is_load | is_store);
  // The core advances on the edge that closes RESP or FAULT.
  assign stall  = mem_op & (state != RESP) & (state != FAULT);

  // Legal access type and natural alignment of the presented operation.
  always_comb begin
    type_ok = 1'b0;
    aligned = 1'b1;
    case (funct3)
      LSU_B, LSU_H, LSU_W: type_ok = 1'b1;
      LSU_BU, LSU_HU:      type_ok = is_load;
      default:             type_ok = 1'b0;
    endcase
    case (funct3)
      LSU_H, LSU_HU: aligned = ~addr[0];
      LSU_W:         aligned = (addr[1:0] == 2'b00);
      default:       aligned = 1'b1;
    endcase
  end

  // Replicate store data across lanes; strobes pick the live bytes.
  always_comb begin
    lanes.wdata = store_data;
    lanes.strb  = 4'b1111;
    case (funct3)
      LSU_B: begin
        lanes.wdata = {4{store_data[7:0]}};
        lanes.strb  = 4'b0001 << addr[1:0];
      end
      LSU_H: begin
        lanes.wdata = {2{store_data[15:0]}};
        lanes.strb  = addr[1] ? 4'b1100 : 4'b0011;
      end
      default: begin
        lanes.wdata = store_data;
        lanes.strb  = 4'b1111;
      end
    endcase
  end

  load_formatter u_load_formatter (
    .rdata    (bus.bus_rdata),
    .offset   (op_offset),
    .funct3   (op_funct3),
    .result_c (load_result)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state         <= IDLE;
      bus.bus_req   <= 1'b0;
      bus.bus_we    <= 1'b0;
      bus.bus_addr  <= '0;
      bus.bus_wdata <= '0;
      bus.bus_strb  <= 4'b0000;
      fault         <= 1'b0;
      wb_enable     <= 1'b0;
      wb_reg        <= 5'd0;
      wb_data       <= '0;
      op_load       <= 1'b0;
      op_funct3     <= 3'b000;
      op_offset     <= 2'b00;
      op_rd         <= 5'd0;
    end else begin
      case (state)
        IDLE: begin
          if (mem_op) begin
            if (!type_ok || !aligned) begin
              state <= FAULT;
              fault <= 1'b1;
            end else begin
              state         <= REQ;
              bus.bus_req   <= 1'b1;
              bus.bus_we    <= is_store;
              bus.bus_addr  <= {addr[XLEN-1:2], 2'b00};
              bus.bus_wdata <= is_store ? lanes.wdata : '0;
              bus.bus_strb  <= is_store ? lanes.strb : 4'b0000;
              op_load       <= is_load;
              op_funct3     <= funct3;
              op_offset     <= addr[1:0];
              op_rd         <= rd;
            end
          end
        end
        REQ: begin
          if (bus.bus_ack) begin
            state       <= RESP;
            bus.bus_req <= 1'b0;
            bus.bus_we  <= 1'b0;
            wb_enable   <= op_load && (op_rd != 5'd0);
            wb_reg      <= op_rd;
            if (op_load) wb_data <= load_result;
          end
        end
        RESP: begin
          state     <= IDLE;
          wb_enable <= 1'b0;
        end
        FAULT: begin
          state <= IDLE;
          fault <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: vector table with a result scoreboard
// plus hand-written reset, stray-ack and formatter sequences.
module tb_load_store_unit;
  import lsu_pkg::*;

  logic        clock = 1'b0;
  logic        reset;
  logic        valid;
  logic        is_load;
  logic        is_store;
  logic [2:0]  funct3;
  logic [31:0] addr;
  logic [31:0] store_data;
  logic [4:0]  rd;
  logic        stall;
  logic        fault;
  logic        wb_enable;
  logic [4:0]  wb_reg;
  logic [31:0] wb_data;

  logic [31:0] f_rdata;
  logic [1:0]  f_off;
  logic [2:0]  f_f3;
  logic [31:0] f_res;

  int checks = 0;
  int errors = 0;

  load_store_unit_if bus ();

  load_store_unit dut (
    .clock      (clock),
    .reset      (reset),
    .valid      (valid),
    .is_load    (is_load),
    .is_store   (is_store),
    .funct3     (funct3),
    .addr       (addr),
    .store_data (store_data),
    .rd         (rd),
    .stall      (stall),
    .fault      (fault),
    .bus        (bus),
    .wb_enable  (wb_enable),
    .wb_reg     (wb_reg),
    .wb_data    (wb_data)
  );

  load_formatter fmt (
    .rdata    (f_rdata),
    .offset   (f_off),
    .funct3   (f_f3),
    .result_c (f_res)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic        ld;
    logic        st;
    logic [2:0]  f3;
    logic [31:0] a;
    logic [31:0] sd;
    logic [4:0]  rd;
    logic [31:0] rdata;
    int          dly;
    logic        e_fault;
    logic        e_wb_en;
    logic [31:0] e_wb_data;
    logic [31:0] e_baddr;
    logic [31:0] e_wdata;
    logic [3:0]  e_strb;
    int          e_stall;
  } vec_t;

  typedef struct packed {
    logic        fault;
    logic        wb_en;
    logic [4:0]  wb_reg;
    logic [31:0] wb_data;
  } exp_t;

  exp_t sb_q[$];
  vec_t vecs[17];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=0x%08h required=0x%08h", name, act, req);
    end
  endtask

  task automatic run_vec(input int idx, input vec_t v);
    exp_t        e;
    int          stall_cnt = 0;
    int          req_cycles = 0;
    bit          req_seen = 1'b0;
    bit          held = 1'b1;
    bit          done = 1'b0;
    logic [31:0] h_addr = '0;
    logic [31:0] h_wdata = '0;
    logic [3:0]  h_strb = '0;
    logic        h_we = 1'b0;
    valid      = 1'b1;
    is_load    = v.ld;
    is_store   = v.st;
    funct3     = v.f3;
    addr       = v.a;
    store_data = v.sd;
    rd         = v.rd;
    sb_q.push_back('{v.e_fault, v.e_wb_en, v.rd, v.e_wb_data});
    for (int c = 0; c < 40 && !done; c++) begin
      @(negedge clock);
      if (bus.bus_req) begin
        if (!req_seen) begin
          req_seen = 1'b1;
          h_addr   = bus.bus_addr;
          h_wdata  = bus.bus_wdata;
          h_strb   = bus.bus_strb;
          h_we     = bus.bus_we;
        end else if ({h_addr, h_wdata, h_strb, h_we} !==
                     {bus.bus_addr, bus.bus_wdata, bus.bus_strb, bus.bus_we}) begin
          held = 1'b0;
        end
        bus.bus_ack   = (req_cycles == v.dly);
        bus.bus_rdata = bus.bus_ack ? v.rdata : 32'hDEAD_BEEF;
        req_cycles++;
      end else begin
        bus.bus_ack = 1'b0;
      end
      if (stall) begin
        stall_cnt++;
      end else begin
        done = 1'b1;
        if (sb_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL v%0d_scoreboard actual=empty required=entry", idx);
        end else begin
          e = sb_q.pop_front();
          check($sformatf("v%0d_fault", idx), 32'(fault), 32'(e.fault));
          check($sformatf("v%0d_wb_enable", idx), 32'(wb_enable), 32'(e.wb_en));
          if (e.wb_en) begin
            check($sformatf("v%0d_wb_data", idx), wb_data, e.wb_data);
            check($sformatf("v%0d_wb_reg", idx), 32'(wb_reg), 32'(e.wb_reg));
          end
        end
      end
    end
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL v%0d_timeout actual=stalled required=complete", idx);
    end
    check($sformatf("v%0d_stall_cycles", idx), 32'(stall_cnt), 32'(v.e_stall));
    check($sformatf("v%0d_req_seen", idx), 32'(req_seen), 32'(!v.e_fault));
    if (!v.e_fault) begin
      check($sformatf("v%0d_bus_addr", idx), h_addr, v.e_baddr);
      check($sformatf("v%0d_bus_strb", idx), 32'(h_strb), 32'(v.e_strb));
      check($sformatf("v%0d_bus_we", idx), 32'(h_we), 32'(v.st));
      if (v.st) check($sformatf("v%0d_bus_wdata", idx), h_wdata, v.e_wdata);
      check($sformatf("v%0d_bus_hold", idx), 32'(held), 32'd1);
    end
    @(posedge clock);
    #1;
    valid       = 1'b0;
    is_load     = 1'b0;
    is_store    = 1'b0;
    bus.bus_ack = 1'b0;
    @(negedge clock);
    check($sformatf("v%0d_post_fault", idx), 32'(fault), 32'd0);
    check($sformatf("v%0d_post_wb_enable", idx), 32'(wb_enable), 32'd0);
    check($sformatf("v%0d_post_bus_req", idx), 32'(bus.bus_req), 32'd0);
    @(posedge clock);
    #1;
  endtask

  initial begin
    bit got_req;

    //          ld    st    f3      addr          sd            rd     rdata         dly flt  wbe   wb_data       baddr         wdata         strb    stall
    vecs[0]  = '{1'b1, 1'b0, 3'b010, 32'h0000_0100, 32'h0,        5'd5,  32'h1234_5678, 0, 1'b0, 1'b1, 32'h1234_5678, 32'h0000_0100, 32'h0,        4'b0000, 2};
    vecs[1]  = '{1'b1, 1'b0, 3'b000, 32'h0000_0103, 32'h0,        5'd6,  32'h80AA_BBCC, 0, 1'b0, 1'b1, 32'hFFFF_FF80, 32'h0000_0100, 32'h0,        4'b0000, 2};
    vecs[2]  = '{1'b1, 1'b0, 3'b100, 32'h0000_0103, 32'h0,        5'd7,  32'h80AA_BBCC, 0, 1'b0, 1'b1, 32'h0000_0080, 32'h0000_0100, 32'h0,        4'b0000, 2};
    vecs[3]  = '{1'b1, 1'b0, 3'b001, 32'h0000_0102, 32'h0,        5'd8,  32'h80AA_BBCC, 1, 1'b0, 1'b1, 32'hFFFF_80AA, 32'h0000_0100, 32'h0,        4'b0000, 3};
    vecs[4]  = '{1'b1, 1'b0, 3'b101, 32'h0000_0100, 32'h0,        5'd9,  32'h1234_F00D, 0, 1'b0, 1'b1, 32'h0000_F00D, 32'h0000_0100, 32'h0,        4'b0000, 2};
    vecs[5]  = '{1'b1, 1'b0, 3'b000, 32'h0000_0101, 32'h0,        5'd10, 32'h0000_7F00, 0, 1'b0, 1'b1, 32'h0000_007F, 32'h0000_0100, 32'h0,        4'b0000, 2};
    vecs[6]  = '{1'b0, 1'b1, 3'b001, 32'h0000_0102, 32'h0000_BEEF, 5'd11, 32'h5555_5555, 0, 1'b0, 1'b0, 32'h0,  32'h0000_0100, 32'hBEEF_BEEF, 4'b1100, 2};
    vecs[7]  = '{1'b0, 1'b1, 3'b000, 32'h0000_0201, 32'h1234_56AB, 5'd12, 32'h5555_5555, 0, 1'b0, 1'b0, 32'h0,  32'h0000_0200, 32'hABAB_ABAB, 4'b0010, 2};
    vecs[8]  = '{1'b0, 1'b1, 3'b010, 32'h0000_0300, 32'hCAFE_F00D, 5'd13, 32'h5555_5555, 3, 1'b0, 1'b0, 32'h0,  32'h0000_0300, 32'hCAFE_F00D, 4'b1111, 5};
    vecs[9]  = '{1'b1, 1'b0, 3'b010, 32'h0000_0101, 32'h0,        5'd14, 32'h0,         0, 1'b1, 1'b0, 32'h0,         32'h0,         32'h0,        4'b0000, 1};
    vecs[10] = '{1'b1, 1'b0, 3'b001, 32'h0000_0103, 32'h0,        5'd15, 32'h0,         0, 1'b1, 1'b0, 32'h0,         32'h0,         32'h0,        4'b0000, 1};
    vecs[11] = '{1'b0, 1'b1, 3'b010, 32'h0000_0102, 32'h1111_2222, 5'd16, 32'h0,        0, 1'b1, 1'b0, 32'h0,         32'h0,         32'h0,        4'b0000, 1};
    vecs[12] = '{1'b0, 1'b1, 3'b100, 32'h0000_0100, 32'h1111_2222, 5'd17, 32'h0,        0, 1'b1, 1'b0, 32'h0,         32'h0,         32'h0,        4'b0000, 1};
    vecs[13] = '{1'b1, 1'b0, 3'b011, 32'h0000_0100, 32'h0,        5'd18, 32'h0,         0, 1'b1, 1'b0, 32'h0,         32'h0,         32'h0,        4'b0000, 1};
    vecs[14] = '{1'b1, 1'b0, 3'b010, 32'h0000_0104, 32'h0,        5'd0,  32'hAAAA_5555, 0, 1'b0, 1'b0, 32'h0,         32'h0000_0104, 32'h0,        4'b0000, 2};
    vecs[15] = '{1'b0, 1'b1, 3'b001, 32'h0000_0100, 32'h1234_ABCD, 5'd19, 32'h5555_5555, 2, 1'b0, 1'b0, 32'h0, 32'h0000_0100, 32'hABCD_ABCD, 4'b0011, 4};
    vecs[16] = '{1'b1, 1'b0, 3'b101, 32'h0000_0103, 32'h0,        5'd20, 32'h0,         0, 1'b1, 1'b0, 32'h0,         32'h0,         32'h0,        4'b0000, 1};

    reset         = 1'b1;
    valid         = 1'b0;
    is_load       = 1'b0;
    is_store      = 1'b0;
    funct3        = 3'b000;
    addr          = '0;
    store_data    = '0;
    rd            = '0;
    bus.bus_ack   = 1'b0;
    bus.bus_rdata = '0;
    f_rdata       = '0;
    f_off         = '0;
    f_f3          = '0;

    // Reset state
    repeat (2) @(posedge clock);
    @(negedge clock);
    check("rst_bus_req", 32'(bus.bus_req), 32'd0);
    check("rst_bus_we", 32'(bus.bus_we), 32'd0);
    check("rst_bus_addr", bus.bus_addr, 32'd0);
    check("rst_bus_wdata", bus.bus_wdata, 32'd0);
    check("rst_bus_strb", 32'(bus.bus_strb), 32'd0);
    check("rst_wb_enable", 32'(wb_enable), 32'd0);
    check("rst_wb_reg", 32'(wb_reg), 32'd0);
    check("rst_wb_data", wb_data, 32'd0);
    check("rst_fault", 32'(fault), 32'd0);
    check("rst_stall", 32'(stall), 32'd0);
    @(posedge clock);
    #1;
    reset = 1'b0;

    // Formatter standalone: lane select and extension
    f_rdata = 32'h80AA_7FCC;
    f_off = 2'd0; f_f3 = LSU_B;  #1; check("fmt_b0", f_res, 32'hFFFF_FFCC);
    f_off = 2'd1; f_f3 = LSU_B;  #1; check("fmt_b1", f_res, 32'h0000_007F);
    f_off = 2'd2; f_f3 = LSU_BU; #1; check("fmt_bu2", f_res, 32'h0000_00AA);
    f_off = 2'd2; f_f3 = LSU_H;  #1; check("fmt_h2", f_res, 32'hFFFF_80AA);
    f_off = 2'd0; f_f3 = LSU_HU; #1; check("fmt_hu0", f_res, 32'h0000_7FCC);
    f_off = 2'd0; f_f3 = LSU_W;  #1; check("fmt_w", f_res, 32'h80AA_7FCC);

    // Stray ack while idle
    @(posedge clock);
    #1;
    bus.bus_ack   = 1'b1;
    bus.bus_rdata = 32'hFFFF_FFFF;
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      check($sformatf("stray%0d_bus_req", i), 32'(bus.bus_req), 32'd0);
      check($sformatf("stray%0d_stall", i), 32'(stall), 32'd0);
      check($sformatf("stray%0d_wb_enable", i), 32'(wb_enable), 32'd0);
    end
    @(posedge clock);
    #1;
    bus.bus_ack = 1'b0;

    for (int i = 0; i < 17; i++) run_vec(i, vecs[i]);

    // Reset while a store is waiting in REQ
    valid      = 1'b1;
    is_store   = 1'b1;
    is_load    = 1'b0;
    funct3     = LSU_W;
    addr       = 32'h0000_0400;
    store_data = 32'h0BAD_F00D;
    rd         = 5'd21;
    got_req    = 1'b0;
    for (int c = 0; c < 10 && !got_req; c++) begin
      @(negedge clock);
      got_req = bus.bus_req;
    end
    check("rstreq_got_req", 32'(got_req), 32'd1);
    reset    = 1'b1;
    valid    = 1'b0;
    is_store = 1'b0;
    @(negedge clock);
    check("rstreq_bus_req", 32'(bus.bus_req), 32'd0);
    check("rstreq_wb_enable", 32'(wb_enable), 32'd0);
    check("rstreq_stall", 32'(stall), 32'd0);
    @(posedge clock);
    #1;
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      check($sformatf("rstreq_after%0d_wb_enable", i), 32'(wb_enable), 32'd0);
      check($sformatf("rstreq_after%0d_bus_req", i), 32'(bus.bus_req), 32'd0);
    end

    // Unit still works after the abandoned access
    @(posedge clock);
    #1;
    run_vec(100, vecs[0]);

    check("sb_drained", 32'(sb_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
